// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
// Groups the psum input beat stream and the accumulated-pixel output stream
// of psum_accumulator into one bundle.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid keeps its payload
// stable until that edge. A consumer may raise or drop ready at any time.
//
// Signals
//   psum       N_PE*PSUM_W  lane k at [PSUM_W*k +: PSUM_W], signed
//   psum_valid 1            beat present
//   psum_last  1            final channel beat of the current pixel
//   psum_ready 1            accumulator accepts a beat this cycle
//   out_data   ACC_W        accumulated pixel sum, signed
//   out_count  CNT_W        beats accumulated into out_data, saturating
//   out_ovf    1            signed overflow seen while accumulating the pixel
//   out_valid  1            result held on the output
//   out_ready  1            consumer takes the result
// Modports
//   master : upstream PE kernel plus downstream write-back (drives beats,
//            takes results)
//   slave  : the accumulator itself
interface psum_accumulator_if #(
  parameter int N_PE   = 9,
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  logic [N_PE*PSUM_W-1:0] psum;
  logic                   psum_valid;
  logic                   psum_last;
  logic                   psum_ready;
  logic [ACC_W-1:0]       out_data;
  logic [CNT_W-1:0]       out_count;
  logic                   out_ovf;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output psum, psum_valid, psum_last, out_ready,
    input  psum_ready, out_data, out_count, out_ovf, out_valid
  );

  modport slave (
    input  psum, psum_valid, psum_last, out_ready,
    output psum_ready, out_data, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Reduces the nine signed partial sums the 3x3 PE kernel produces per beat
// through a two-stage adder tree (three 3-lane group sums, then their total)
// and accumulates the beat totals over input channels until a beat marked
// psum_last. The finished pixel is presented on a valid/ready output.
//
// Pipeline: S1 (group sums) -> S2 (tree total) -> accumulate/output register.
// A single advance enable freezes every stage while the output holds an
// unaccepted result, so at most two beats sit in flight during a stall.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   bus        psum_accumulator_if.slave (beat input, pixel output)
//   dbg_state  accumulate FSM state (0 = IDLE, 1 = ACCUM)
module psum_accumulator #(
  parameter int N_PE   = 9,
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_accumulator_if.slave    bus,
  output logic [0:0]           dbg_state
);

  localparam int N_GRP = N_PE / 3;
  // Three lanes add at most 2 bits, three groups at most 2 more.
  localparam int G_W   = PSUM_W + 2;
  localparam int T_W   = PSUM_W + 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                     en;
  logic signed [G_W-1:0]    g_next [N_GRP];

  logic                     s1_valid;
  logic                     s1_last;
  logic signed [G_W-1:0]    s1_g [N_GRP];
  logic signed [T_W-1:0]    t_next;

  logic                     s2_valid;
  logic                     s2_last;
  logic signed [T_W-1:0]    s2_t;

  logic [0:0]               state;
  logic [ACC_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf;

  logic [ACC_W-1:0]         acc_base;
  logic [CNT_W-1:0]         cnt_base;
  logic                     ovf_base;
  logic [ACC_W-1:0]         t_ext;
  logic [ACC_W-1:0]         sum;
  logic                     add_ovf;
  logic                     ovf_new;
  logic [CNT_W-1:0]         cnt_new;

  // The whole pipeline advances unless a finished result is waiting.
  assign en             = ~bus.out_valid | bus.out_ready;
  assign bus.psum_ready = en;
  assign dbg_state      = state;

  // Stage 1 combinational: group g sums lanes 3g..3g+2, sign-extended.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      g_next[g] = '0;
      for (int j = 0; j < 3; j++) begin
        g_next[g] = g_next[g] + G_W'($signed(bus.psum[(3*g+j)*PSUM_W +: PSUM_W]));
      end
    end
  end

  // Stage 2 combinational: exact tree total of the registered group sums.
  always_comb begin
    t_next = '0;
    for (int g = 0; g < N_GRP; g++) begin
      t_next = t_next + T_W'(s1_g[g]);
    end
  end

  // Accumulate stage: IDLE starts a fresh pixel from zero bases.
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    cnt_base = (state == ACCUM) ? cnt : '0;
    ovf_base = (state == ACCUM) ? ovf : 1'b0;
    t_ext    = ACC_W'(s2_t);
    sum      = acc_base + t_ext;
    // Signed overflow: operands agree in sign, result disagrees.
    add_ovf  = (acc_base[ACC_W-1] == t_ext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc_base[ACC_W-1]);
    ovf_new  = ovf_base | add_ovf;
    cnt_new  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int g = 0; g < N_GRP; g++) begin
        s1_g[g] <= '0;
      end
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_t     <= '0;
    end else if (en) begin
      s1_valid <= bus.psum_valid;
      s1_last  <= bus.psum_last;
      if (bus.psum_valid) begin
        for (int g = 0; g < N_GRP; g++) begin
          s1_g[g] <= g_next[g];
        end
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_t <= t_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (en && s2_valid) begin
      if (s2_last) begin
        // Loading a new result may coincide with the consumer taking the
        // previous one; the new value simply replaces it.
        bus.out_data  <= sum;
        bus.out_count <= cnt_new;
        bus.out_ovf   <= ovf_new;
        bus.out_valid <= 1'b1;
        state         <= IDLE;
      end else begin
        acc           <= sum;
        cnt           <= cnt_new;
        ovf           <= ovf_new;
        state         <= ACCUM;
        if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
        end
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
